// File: rtl/hyper_rx_pkg.sv
// rtl/hyper_rx_pkg.sv - shared types for the HyperBus read-data packer
package hyper_rx_pkg;

  localparam int unsigned RxDataWidth = 64;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN
  } rx_state_e;

  typedef struct packed {
    logic [RxDataWidth-1:0] data;
    logic                   last;
    logic                   error;
  } rx_beat_t;

  // Lane counter width; a single-lane packer still needs one bit.
  function automatic int unsigned lane_width(input int unsigned ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/hyper_rx_skid.sv
// rtl/hyper_rx_skid.sv - one-entry valid/ready skid buffer for packed read beats
module hyper_rx_skid
  import hyper_rx_pkg::*;
#(
  parameter type beat_t = rx_beat_t
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  valid_i,
  output logic  ready_o,
  input  beat_t beat_i,
  output logic  valid_o,
  input  logic  ready_i,
  output beat_t beat_o
);

  logic  full_q;
  beat_t skid_q;

  assign ready_o = !full_q;
  assign valid_o = full_q || valid_i;
  assign beat_o  = full_q ? skid_q : beat_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      skid_q <= '0;
    end else if (!full_q && valid_i && !ready_i) begin
      full_q <= 1'b1;
      skid_q <= beat_i;
    end else if (full_q && ready_i) begin
      full_q <= 1'b0;
    end
  end

endmodule

// File: rtl/hyper_rx_upsizer.sv
// rtl/hyper_rx_upsizer.sv - packs HyperBus PHY read words into AXI R beats
// HYPER_RX_UPSIZER_SKID_EN: skid stage after the output register, phy_ready_o fully registered.
module hyper_rx_upsizer
  import hyper_rx_pkg::*;
#(
  parameter int unsigned AxiDataWidth = 64,
  parameter int unsigned NumPhys      = 2,
  localparam int unsigned PhyW        = 16 * NumPhys,
  localparam int unsigned OffW        = $clog2(AxiDataWidth / 8)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    trx_valid_i,
  output logic                    trx_ready_o,
  input  logic [OffW-1:0]         trx_offset_i,
  input  logic [7:0]              trx_len_i,
  input  logic                    phy_valid_i,
  output logic                    phy_ready_o,
  input  logic [PhyW-1:0]         phy_data_i,
  input  logic                    phy_error_i,
  output logic                    r_valid_o,
  input  logic                    r_ready_i,
  output logic [AxiDataWidth-1:0] r_data_o,
  output logic                    r_last_o,
  output logic                    r_error_o
);

  localparam int unsigned Ratio     = AxiDataWidth / PhyW;
  localparam int unsigned LaneW     = lane_width(Ratio);
  localparam int unsigned ByteShift = $clog2(PhyW / 8);
  localparam logic [LaneW-1:0] LastLane = LaneW'(Ratio - 1);

  typedef struct packed {
    logic [AxiDataWidth-1:0] data;
    logic                    last;
    logic                    error;
  } beat_t;

  if (Ratio < 1 || (Ratio & (Ratio - 1)) != 0 || Ratio * PhyW != AxiDataWidth) begin : g_bad_ratio
    $error("hyper_rx_upsizer: AxiDataWidth/PhyW must be a power of two and at least 1");
  end

  rx_state_e               state_q, state_d;
  logic [LaneW-1:0]        lane_q, start_lane;
  logic [7:0]              beats_left_q;
  logic                    err_acc_q;
  logic [AxiDataWidth-1:0] acc_q, acc_d;
  int unsigned             lane_base;
  beat_t                   beat_q;
  logic                    beat_valid_q;
  logic                    out_ready, slot_free;
  logic                    trx_fire, phy_fire, beat_done;
  logic [OffW-1:0]         offset_words;
  logic                    unused_offset;

  assign offset_words  = trx_offset_i >> ByteShift;
  assign unused_offset = ^offset_words;
  assign start_lane    = (Ratio == 1) ? '0 : offset_words[LaneW-1:0];

  assign slot_free   = !beat_valid_q || out_ready;
  assign trx_ready_o = rst_ni && (state_q == IDLE);
  assign phy_ready_o = (state_q == COLLECT) && (slot_free || lane_q != LastLane);
  assign trx_fire    = trx_valid_i && trx_ready_o;
  assign phy_fire    = phy_valid_i && phy_ready_o;
  assign beat_done   = phy_fire && (lane_q == LastLane);

  // The final lane goes straight into the output beat via acc_d.
  always_comb begin
    lane_base = 32'(lane_q) * PhyW;
    acc_d     = acc_q;
    acc_d[lane_base +: PhyW] = phy_data_i;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (trx_fire) state_d = COLLECT;
      COLLECT: if (beat_done && beats_left_q == 8'd0) state_d = DRAIN;
      DRAIN:   if (r_valid_o && r_ready_i && r_last_o) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      lane_q       <= '0;
      beats_left_q <= 8'd0;
      err_acc_q    <= 1'b0;
      acc_q        <= '0;
    end else begin
      state_q <= state_d;
      if (trx_fire) begin
        lane_q       <= start_lane;
        beats_left_q <= trx_len_i;
        err_acc_q    <= 1'b0;
      end else if (phy_fire) begin
        acc_q <= acc_d;
        if (beat_done) begin
          lane_q    <= '0;
          err_acc_q <= 1'b0;
          if (beats_left_q != 8'd0) beats_left_q <= beats_left_q - 8'd1;
        end else begin
          lane_q    <= lane_q + LaneW'(1);
          err_acc_q <= err_acc_q | phy_error_i;
        end
      end
    end
  end

  // A beat only completes when the output slot is free, so a stalled beat is never overwritten.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      beat_valid_q <= 1'b0;
      beat_q       <= '0;
    end else if (beat_done) begin
      beat_valid_q <= 1'b1;
      beat_q       <= '{data: acc_d, last: (beats_left_q == 8'd0), error: err_acc_q | phy_error_i};
    end else if (beat_valid_q && out_ready) begin
      beat_valid_q <= 1'b0;
    end
  end

`ifdef HYPER_RX_UPSIZER_SKID_EN
  beat_t r_beat;

  hyper_rx_skid #(
    .beat_t (beat_t)
  ) u_skid (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (beat_valid_q),
    .ready_o (out_ready),
    .beat_i  (beat_q),
    .valid_o (r_valid_o),
    .ready_i (r_ready_i),
    .beat_o  (r_beat)
  );

  assign r_data_o  = r_beat.data;
  assign r_last_o  = r_beat.last;
  assign r_error_o = r_beat.error;
`else
  assign out_ready = r_ready_i;
  assign r_valid_o = beat_valid_q;
  assign r_data_o  = beat_q.data;
  assign r_last_o  = beat_q.last;
  assign r_error_o = beat_q.error;
`endif

endmodule
